// File: rtl/bus_mem_ctrl.sv
// -----------------------------------------------------------------------------
// bus_mem_ctrl
//
// Bridge between the core's request/acknowledge data bus and a single-port
// synchronous RAM.  A byte/half/word request is checked against the RAM
// address window and its alignment rules.  Good requests become one RAM
// access (chip select, write enable, byte enables, lane-replicated write
// data).  Reads wait RD_LAT cycles for RAM data and return it shifted down to
// bit 0 and zero-extended to the access size.  Every request, good or bad,
// finishes with a one-cycle acknowledge.  A bad request sets o_err and never
// touches the RAM.
//
// Parameters
//   BASE_ADDR  byte address of RAM word 0 (4-byte aligned)
//   MEM_DEPTH  RAM depth in 32-bit words (power of two, >= 2)
//   RD_LAT     cycles from the read chip select to valid i_rd_data (0..3)
//   AW         RAM word-address width, derived from MEM_DEPTH
//
// Ports
//   i_clk, i_rst             clock, asynchronous active-high reset
//   i_bus_en                 request valid, held with its fields until o_ack
//   i_wr_rd                  1 = write, 0 = read
//   i_addr, i_size           byte address; size 00 byte, 01 half, 10 word
//   i_wr_data                right-justified write data
//   o_ack, o_err             completion pulse and fault flag
//   o_rd_data                aligned read data, valid with o_ack
//   o_cs, o_wr_en, o_b_en    RAM chip select, write enable, byte enables
//   o_addr, o_wr_data        RAM word address, lane-replicated write data
//   i_rd_data                RAM read data
// -----------------------------------------------------------------------------
module bus_mem_ctrl #(
   parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
   parameter int          MEM_DEPTH = 4096,
   parameter int          RD_LAT    = 2,
   parameter int          AW        = $clog2(MEM_DEPTH)
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_bus_en,
   input  logic          i_wr_rd,
   input  logic [31:0]   i_addr,
   input  logic [1:0]    i_size,
   input  logic [31:0]   i_wr_data,
   output logic          o_ack,
   output logic          o_err,
   output logic [31:0]   o_rd_data,
   output logic          o_cs,
   output logic          o_wr_en,
   output logic [3:0]    o_b_en,
   output logic [AW-1:0] o_addr,
   output logic [31:0]   o_wr_data,
   input  logic [31:0]   i_rd_data
);

   // Window size in bytes; 33 bits so a 4 GiB window cannot wrap to zero.
   localparam logic [32:0] WIN_BYTES = 33'(MEM_DEPTH) * 33'd4;
   localparam logic [1:0]  LAT_CNT   = 2'(RD_LAT);
   localparam bit          LAT_ZERO  = (RD_LAT == 0);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_WAIT = 2'd1,
      RESP    = 2'd2
   } state_t;

   state_t         state_reg, state_next;
   logic [1:0]     cnt_reg, cnt_next;
   logic [AW-1:0]  addr_reg;
   logic [1:0]     off_reg;
   logic [1:0]     size_reg;
   logic           wr_reg;
   logic           err_reg;
   logic [31:0]    wdata_reg;

   logic [31:0]    rel_addr;
   logic           req_fault;
   logic           accept;
   logic           rd_valid;
   logic [31:0]    rd_shift;
   logic [3:0]     be_lanes;
   logic [31:0]    wdata_lanes;
   logic [31:0]    rdata_lanes;

   // Request decode.  The window test works on the unsigned difference, so an
   // address just below BASE_ADDR wraps to a huge offset and faults as well.
   always_comb begin
      rel_addr  = i_addr - BASE_ADDR;
      req_fault = (i_size == 2'b11)
               || (i_size == 2'b01 && i_addr[0])
               || (i_size == 2'b10 && i_addr[1:0] != 2'b00)
               || ({1'b0, rel_addr} >= WIN_BYTES);
   end

   assign accept = (state_reg == IDLE) && i_bus_en;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_reg <= IDLE;
         cnt_reg   <= 2'd0;
         addr_reg  <= '0;
         off_reg   <= 2'd0;
         size_reg  <= 2'd0;
         wr_reg    <= 1'b0;
         err_reg   <= 1'b0;
         wdata_reg <= 32'd0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         if (accept) begin
            addr_reg  <= rel_addr[AW+1:2];
            off_reg   <= i_addr[1:0];
            size_reg  <= i_size;
            wr_reg    <= i_wr_rd;
            err_reg   <= req_fault;
            wdata_reg <= i_wr_data;
         end
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      o_ack      = 1'b0;
      o_err      = 1'b0;
      o_cs       = 1'b0;
      o_wr_en    = 1'b0;
      rd_valid   = 1'b0;
      case (state_reg)
         IDLE: begin
            if (i_bus_en) begin
               // Writes and faults complete in the next cycle; so does a read
               // when the RAM returns data combinationally.
               if (req_fault || i_wr_rd || LAT_ZERO) begin
                  state_next = RESP;
               end else begin
                  state_next = RD_WAIT;
                  cnt_next   = LAT_CNT;
               end
            end
         end
         RD_WAIT: begin
            // The counter still holds its load value only in the first cycle,
            // which is the one cycle the read strobe is issued.
            o_cs = (cnt_reg == LAT_CNT);
            if (cnt_reg <= 2'd1) begin
               state_next = RESP;
               cnt_next   = 2'd0;
            end else begin
               cnt_next = cnt_reg - 2'd1;
            end
         end
         RESP: begin
            o_ack      = 1'b1;
            o_err      = err_reg;
            o_cs       = !err_reg && (wr_reg || LAT_ZERO);
            o_wr_en    = !err_reg && wr_reg;
            rd_valid   = !err_reg && !wr_reg;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign rd_shift = i_rd_data >> {off_reg, 3'b000};

   // Per byte lane: enable, replicated write byte and read-data keep mask.
   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      logic lane_keep;

      assign be_lanes[gi] = (size_reg == 2'b00 && off_reg == LANE)
                         || (size_reg == 2'b01 && off_reg[1] == LANE[1])
                         || (size_reg == 2'b10);

      assign wdata_lanes[8*gi +: 8] =
         (size_reg == 2'b00) ? wdata_reg[7:0] :
         (size_reg == 2'b01) ? (LANE[0] ? wdata_reg[15:8] : wdata_reg[7:0]) :
                               wdata_reg[8*gi +: 8];

      // Zero-extension: only the low 1, 2 or 4 lanes survive the shift.
      assign lane_keep = (size_reg == 2'b00 && LANE == 2'd0)
                      || (size_reg == 2'b01 && !LANE[1])
                      || (size_reg == 2'b10);

      assign rdata_lanes[8*gi +: 8] = (rd_valid && lane_keep) ? rd_shift[8*gi +: 8] : 8'h00;
   end

   // RAM-side fields are forced to zero whenever the RAM is not selected.
   assign o_b_en    = o_cs ? be_lanes    : 4'b0000;
   assign o_addr    = o_cs ? addr_reg    : '0;
   assign o_wr_data = o_cs ? wdata_lanes : 32'd0;
   assign o_rd_data = rdata_lanes;

endmodule

// File: tb/tb_bus_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bus_mem_ctrl
//
// Four bridge instances, one per read latency 0..3, each with its own RAM
// model, reset, driver and scoreboard.  The driver pushes the expected
// response of every request (computed from a plain word-array reference
// memory) into a queue; the monitor pops on each acknowledge and also checks
// the RAM strobe cycle, address, byte enables and write data.
// -----------------------------------------------------------------------------
module tb_bus_mem_ctrl;

   localparam logic [31:0] BASE  = 32'h8000_0000;
   localparam int          DEPTH = 4096;
   localparam int          AW    = 12;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;
   int lanes_done = 0;

   typedef struct {
      bit            wr;
      bit            err;
      logic [31:0]   rdata;
      int            cs_cyc;
      int            ack_cyc;
      logic [3:0]    be;
      logic [AW-1:0] waddr;
      logic [31:0]   wdata;
   } exp_t;

   task automatic check(input int lane, input bit ok, input string name,
                        input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL lat%0d %s actual=%h required=%h cycle=%0d", lane, name, act, exp, cyc);
      end
   endtask

   task automatic lane_finished();
      lanes_done++;
   endtask

   // ---- reference rules -----------------------------------------------------
   function automatic bit is_fault(input logic [31:0] a, input logic [1:0] sz);
      logic [31:0] rel;
      rel = a - BASE;
      return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0)
          || (rel >= 32'(DEPTH * 4));
   endfunction

   function automatic int nbytes(input logic [1:0] sz);
      return 1 << sz;
   endfunction

   function automatic logic [3:0] be_of(input logic [31:0] a, input logic [1:0] sz);
      int nb;
      nb = nbytes(sz);
      return 4'(((1 << nb) - 1) << a[1:0]);
   endfunction

   function automatic logic [31:0] rep_of(input logic [1:0] sz, input logic [31:0] wd);
      logic [31:0] r;
      int nb;
      nb = nbytes(sz);
      for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % nb) +: 8];
      return r;
   endfunction

   function automatic logic [31:0] mask_of(input logic [1:0] sz);
      int nb;
      nb = nbytes(sz);
      return (nb >= 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*nb)) - 32'd1);
   endfunction

   // ---- one bridge per read latency -----------------------------------------
   for (genvar gi = 0; gi < 4; gi++) begin : g_lat
      localparam int LAT = gi;

      logic          rst, bus_en, wr_rd;
      logic [31:0]   addr, wdata;
      logic [1:0]    size;
      logic          ack, err, cs, wr_en;
      logic [31:0]   rdata, ram_wdata, ram_rdata;
      logic [3:0]    b_en;
      logic [AW-1:0] ram_addr;

      bit [31:0] ram  [DEPTH];
      bit [31:0] refm [DEPTH];
      exp_t      q[$];
      exp_t      em;
      int        cs_cnt = 0;

      bus_mem_ctrl #(
         .BASE_ADDR (BASE),
         .MEM_DEPTH (DEPTH),
         .RD_LAT    (LAT)
      ) dut (
         .i_clk     (clk),
         .i_rst     (rst),
         .i_bus_en  (bus_en),
         .i_wr_rd   (wr_rd),
         .i_addr    (addr),
         .i_size    (size),
         .i_wr_data (wdata),
         .o_ack     (ack),
         .o_err     (err),
         .o_rd_data (rdata),
         .o_cs      (cs),
         .o_wr_en   (wr_en),
         .o_b_en    (b_en),
         .o_addr    (ram_addr),
         .o_wr_data (ram_wdata),
         .i_rd_data (ram_rdata)
      );

      // Single-port RAM model with byte writes and RD_LAT read latency.
      always @(posedge clk) begin
         if (cs && wr_en)
            for (int i = 0; i < 4; i++)
               if (b_en[i]) ram[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
      end

      if (LAT == 0) begin : g_comb
         assign ram_rdata = ram[ram_addr];
      end else begin : g_pipe
         logic [31:0] pipe [LAT];
         always @(posedge clk) begin
            pipe[0] <= (cs && !wr_en) ? ram[ram_addr] : 32'h0BAD_0BAD;
            for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
         end
         assign ram_rdata = pipe[LAT-1];
      end

      function automatic bit outs_zero();
         return !(ack || err || cs || wr_en) && rdata == 32'd0 && b_en == 4'd0
             && ram_addr == '0 && ram_wdata == 32'd0;
      endfunction

      // Monitor: compares whatever the DUT presents against the queue head.
      initial begin
         forever begin
            @(negedge clk);
            if (rst) begin
               cs_cnt = 0;
            end else if (q.size() == 0) begin
               check(gi, outs_zero(), "idle_quiet",
                     {ack, err, cs, wr_en, b_en, 24'd0}, 32'd0);
            end else begin
               em = q[0];
               if (cs) begin
                  check(gi, !em.err, "cs_on_fault", 32'(cs), 32'd0);
                  check(gi, cyc == em.cs_cyc, "cs_cycle", cyc, em.cs_cyc);
                  check(gi, wr_en == em.wr, "wr_en", 32'(wr_en), 32'(em.wr));
                  check(gi, ram_addr == em.waddr, "ram_addr", 32'(ram_addr), 32'(em.waddr));
                  check(gi, b_en == em.be, "b_en", 32'(b_en), 32'(em.be));
                  if (em.wr) check(gi, ram_wdata == em.wdata, "ram_wdata", ram_wdata, em.wdata);
                  cs_cnt++;
               end
               if (ack) begin
                  check(gi, cyc == em.ack_cyc, "ack_cycle", cyc, em.ack_cyc);
                  check(gi, err == em.err, "err", 32'(err), 32'(em.err));
                  check(gi, rdata == em.rdata, "rd_data", rdata, em.rdata);
                  check(gi, cs_cnt == (em.err ? 0 : 1), "cs_count", cs_cnt, em.err ? 0 : 1);
                  void'(q.pop_front());
                  cs_cnt = 0;
               end else if (cyc > em.ack_cyc) begin
                  check(gi, 1'b0, "ack_missing", cyc, em.ack_cyc);
                  void'(q.pop_front());
                  cs_cnt = 0;
               end
            end
         end
      end

      // Issue one request at posedge+1 and hold it until the acknowledge.
      task automatic issue(input bit w, input logic [31:0] a, input logic [1:0] sz,
                           input logic [31:0] wd);
         exp_t e;
         int   n;
         int   widx;
         e.wr      = w;
         e.err     = is_fault(a, sz);
         e.be      = be_of(a, sz);
         e.waddr   = AW'((a - BASE) >> 2);
         e.wdata   = rep_of(sz, wd);
         e.rdata   = 32'd0;
         e.cs_cyc  = cyc + 1;
         e.ack_cyc = cyc + 1 + ((w || e.err) ? 0 : LAT);
         if (!e.err) begin
            widx = int'(e.waddr);
            if (w) begin
               for (int i = 0; i < 4; i++)
                  if (e.be[i]) refm[widx][8*i +: 8] = e.wdata[8*i +: 8];
            end else begin
               e.rdata = (refm[widx] >> (8*a[1:0])) & mask_of(sz);
            end
         end
         q.push_back(e);
         bus_en = 1'b1;
         wr_rd  = w;
         addr   = a;
         size   = sz;
         wdata  = wd;
         n = 0;
         do begin
            @(negedge clk);
            n++;
         end while (!ack && n < 10);
         if (!ack) check(gi, 1'b0, "driver_ack_wait", n, LAT + 1);
         @(posedge clk);
         #1;
         bus_en = 1'b0;
         wr_rd  = 1'($urandom);
         addr   = $urandom;
         size   = 2'($urandom);
         wdata  = $urandom;
      endtask

      initial begin
         logic [31:0] a;
         logic [1:0]  sz;
         int          r, g;
         rst = 1'b1; bus_en = 1'b0; wr_rd = 1'b0; addr = 32'd0; size = 2'd0; wdata = 32'd0;
         @(posedge clk);
         #1;
         check(gi, outs_zero(), "reset_outputs", {ack, err, cs, wr_en, b_en, 24'd0}, 32'd0);
         @(posedge clk);
         #1;
         rst = 1'b0;

         // Word write / read back
         issue(1'b1, 32'h8000_0010, 2'd2, 32'hDEAD_BEEF);
         issue(1'b0, 32'h8000_0010, 2'd2, 32'd0);
         // Byte write into the top lane of a known word
         issue(1'b1, 32'h8000_0000, 2'd2, 32'h1122_3344);
         issue(1'b1, 32'h8000_0003, 2'd0, 32'h0000_005A);
         issue(1'b0, 32'h8000_0000, 2'd2, 32'd0);
         // Half read of the upper half
         issue(1'b1, 32'h8000_0010, 2'd2, 32'h1234_ABCD);
         issue(1'b0, 32'h8000_0012, 2'd1, 32'd0);
         issue(1'b0, 32'h8000_0011, 2'd0, 32'd0);
         // Faults: misaligned, illegal size, past the window, below the base
         issue(1'b0, 32'h8000_0002, 2'd2, 32'd0);
         issue(1'b0, 32'h8000_0001, 2'd1, 32'd0);
         issue(1'b0, 32'h8000_0000, 2'd3, 32'd0);
         issue(1'b0, 32'h8000_4000, 2'd2, 32'd0);
         issue(1'b1, 32'h8000_4000, 2'd2, 32'hFFFF_FFFF);
         issue(1'b0, 32'h7FFF_FFFC, 2'd2, 32'd0);
         // Last word of the window
         issue(1'b1, 32'h8000_3FFC, 2'd2, 32'hA5A5_0F0F);
         issue(1'b0, 32'h8000_3FFE, 2'd1, 32'd0);

         // Reset in the cycle after acceptance of a read: aborted, no ack
         issue(1'b1, 32'h8000_0020, 2'd2, 32'hCAFE_F00D);
         bus_en = 1'b1; wr_rd = 1'b0; addr = 32'h8000_0020; size = 2'd2;
         @(posedge clk);
         #2;
         rst = 1'b1;
         bus_en = 1'b0;
         #1;
         check(gi, outs_zero(), "reset_abort_outputs", {ack, err, cs, wr_en, b_en, 24'd0}, 32'd0);
         @(posedge clk);
         #1;
         rst = 1'b0;
         repeat (LAT + 2) @(posedge clk);
         #1;
         issue(1'b0, 32'h8000_0020, 2'd2, 32'd0);

         // Random traffic, mostly back-to-back
         for (int t = 0; t < 150; t++) begin
            r = $urandom_range(0, 9);
            sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            r = $urandom_range(0, 9);
            if (r < 8)       a = BASE + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
            else if (r == 8) a = BASE + 32'(DEPTH * 4 - 4) + 32'($urandom_range(0, 3));
            else             a = $urandom;
            if (sz != 2'd3 && $urandom_range(0, 3) != 0) a = a & ~32'(nbytes(sz) - 1);
            issue(1'($urandom), a, sz, $urandom);
            g = (t % 4 == 0) ? $urandom_range(0, 2) : 0;
            if (g > 0) begin
               repeat (g) @(posedge clk);
               #1;
            end
         end
         repeat (LAT + 3) @(posedge clk);
         lane_finished();
      end
   end

   initial begin
      int waited;
      waited = 0;
      while (lanes_done < 4 && waited < 40000) begin
         @(posedge clk);
         waited++;
      end
      if (lanes_done < 4) begin
         checks++;
         errors++;
         $display("FAIL global_timeout lanes_done=%0d required=4", lanes_done);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/bus_mem_ctrl.md
# bus_mem_ctrl

Parametrised bridge between the core's request/acknowledge data bus and a single-port synchronous RAM. It decodes a byte/half/word request against a configurable address window and generates RAM chip-select, write-enable and byte enables. It waits a configurable RAM read latency, then returns aligned read data with a one-cycle acknowledge. Misaligned and out-of-window accesses are flagged as errors. It sits between the core and `sp_ram`, replacing direct port wiring.

## Interface
- `BASE_ADDR`, 32'h8000_0000, byte address of RAM word 0; must be 4-byte aligned.
- `MEM_DEPTH`, 4096, RAM depth in 32-bit words; power of two, at least 2.
- `RD_LAT`, 2, cycles from RAM `o_cs` (read) to valid `i_rd_data`; range 0..3.
- `AW`, $clog2(MEM_DEPTH), RAM word-address width; derived, not overridden.
- `i_clk`  in  1  clock; all logic on rising edge.
- `i_rst`  in  1  reset; one clock; reset is asynchronous and active-high.
- `i_bus_en`  in  1  request valid; held with the request fields until `o_ack`.
- `i_wr_rd`  in  1  1 = write, 0 = read.
- `i_addr`  in  32  byte address.
- `i_size`  in  2  00 byte, 01 half, 10 word, 11 illegal.
- `i_wr_data`  in  32  write data, right-justified.
- `o_ack`  out  1  one-cycle completion pulse.
- `o_err`  out  1  valid with `o_ack`; 1 = access fault, no RAM access made.
- `o_rd_data`  out  32  read data, shifted to LSB and zero-extended to size; valid with `o_ack` on a successful read, otherwise 0.
- `o_cs`  out  1  RAM chip select.
- `o_wr_en`  out  1  RAM write enable.
- `o_b_en`  out  4  RAM byte enables.
- `o_addr`  out  AW  RAM word address.
- `o_wr_data`  out  32  lane-replicated write data.
- `i_rd_data`  in  32  RAM read data.

## Operation
- FSM states: IDLE, RD_WAIT, RESP.
- IDLE with `i_bus_en`=1: request accepted; address, size, offset and write data registered.
- Fault if `i_size`=11, half with `i_addr[0]`=1, word with `i_addr[1:0]`≠0, or `i_addr`−`BASE_ADDR` (32-bit unsigned) ≥ MEM_DEPTH*4.
  - Fault: go to RESP with err=1; `o_cs` stays 0.
- Write without fault: go to RESP; `o_cs`=`o_wr_en`=1 for exactly that RESP cycle.
- Read without fault:
  - `o_cs`=1, `o_wr_en`=0 for one cycle (first RD_WAIT cycle).
  - A down-counter loaded with RD_LAT runs; when data is due, go to RESP.
  - With RD_LAT=0 the read goes directly to RESP, with `o_cs` asserted in RESP.
- RESP: `o_ack`=1 for one cycle, then back to IDLE. `i_bus_en` is not sampled in RESP.
  - The master drops or changes its request on the edge where it sees `o_ack`.
  - A back-to-back request is accepted in the IDLE cycle that follows.
- `o_addr` = (`i_addr`−`BASE_ADDR`)[AW+1:2].
- Byte enables:
  - byte: 4'b0001 << off.
  - half: 4'b0011 << {off[1],0}.
  - word: 4'b1111.
- `o_wr_data`: byte replicated into 4 lanes, half into 2, word unchanged.
- Read alignment: `o_rd_data` = `i_rd_data` >> (8*off), masked to 8/16/32 bits. The core performs sign extension.
- RAM-side outputs other than `o_cs`/`o_wr_en` are don't-care when `o_cs`=0, but are driven 0.

## Timing
- Reset values: all outputs 0, FSM in IDLE, counter 0.
- Reset asserted mid-operation: abort immediately; no `o_ack`. A pending RAM write is not issued if reset arrives before its RESP cycle.
- Request accepted at edge T (cycle T in IDLE).
- Write: `o_cs`/`o_wr_en`/`o_ack` high in cycle T+1. Throughput is one write per 2 cycles.
- Read:
  - `o_cs` high in cycle T+1.
  - `o_ack` and data in cycle T+1+RD_LAT.
  - For RD_LAT=0, `o_cs`, `o_ack` and data are all in T+1, with RAM data combinational.
- Fault: `o_ack`=`o_err`=1 in T+1.
- `i_bus_en` low in IDLE: no activity; outputs stay 0.

## Test plan
- **Word write/read:** write 0xDEADBEEF to 0x8000_0010, then read it → write ack at T+1 with `o_b_en`=1111 and `o_addr`=4; read ack at T+3 (RD_LAT=2) with `o_rd_data`=0xDEADBEEF and `o_err`=0.
- **Byte write:** byte write 0x5A to 0x8000_0003 → `o_b_en`=1000, `o_wr_data`=0x5A5A5A5A. A following word read returns 0x5Axxxxxx with the other bytes unchanged.
- **Half read:** half read at 0x8000_0012 of word 0x1234ABCD → `o_rd_data`=0x00001234.
- **Faults:** word read at 0x8000_0002, half at 0x8000_0001, `i_size`=11, and address 0x8000_4000 (MEM_DEPTH=4096) → each gives `o_ack`=`o_err`=1 at T+1 with `o_cs` never asserted. Address 0x7FFF_FFFC also faults through wrap-around.
- **Reset mid-read:** assert `i_rst` in the RD_WAIT cycle → all outputs 0 at once, no `o_ack`; the next request after reset completes normally.
- **Latency sweep:** RD_LAT=0,1,3 with back-to-back reads → `o_ack` exactly RD_LAT+1 cycles after acceptance; a new request is accepted the cycle after each ack.
